// File: rtl/msrv32_integer_file_sb.sv
`default_nettype none
// ============================================================================
// Module   : msrv32_integer_file_sb
// Brief    : 2R/1W integer register file with pending-write scoreboard and
//            a sequential clear engine, so the storage needs no per-flop reset.
// Revision : 1.0 - initial release
// ============================================================================
module msrv32_integer_file_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              ms_risc32_mp_clk_in,
    input  logic              ms_risc32_mp_rst_in,
    input  logic [ADDR_W-1:0] rs_1_addr_in,
    input  logic [ADDR_W-1:0] rs_2_addr_in,
    output logic [XLEN-1:0]   rs_1_out,
    output logic [XLEN-1:0]   rs_2_out,
    output logic              rs_1_busy_out,
    output logic              rs_2_busy_out,
    input  logic [ADDR_W-1:0] rd_addr_in,
    input  logic [XLEN-1:0]   rd_in,
    input  logic              wr_en_in,
    input  logic              set_busy_en_in,
    input  logic [ADDR_W-1:0] set_busy_addr_in,
    input  logic              clr_req_in,
    output logic              ready_out
);

    localparam logic [0:0]        S_CLEAR    = 1'b0;
    localparam logic [0:0]        S_READY    = 1'b1;
    localparam logic [ADDR_W:0]   c_NREGS    = (ADDR_W+1)'(NREGS);
    localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(NREGS - 1);

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_clr_idx;
    logic [XLEN-1:0]   r_regs [NREGS];
    logic [NREGS-1:0]  r_busy;
    logic [NREGS-1:0]  w_busy_nxt;
    logic              w_ready;
    logic              w_clearing;
    logic              w_rd_in_range;
    logic              w_wr_ok;
    logic              w_set_ok;

    logic [ADDR_W-1:0] w_rs_addr [2];
    logic [XLEN-1:0]   w_rs_data [2];
    logic              w_rs_busy [2];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge ms_risc32_mp_clk_in) begin
        if (ms_risc32_mp_rst_in) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CLEAR: if (r_clr_idx == c_LAST_IDX) w_state_nxt = S_READY;
            S_READY: if (clr_req_in)              w_state_nxt = S_CLEAR;
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_ready    = (r_state == S_READY);
        w_clearing = (r_state == S_CLEAR);
    end

    assign ready_out = w_ready;

    always_ff @(posedge ms_risc32_mp_clk_in) begin
        if (ms_risc32_mp_rst_in) begin
            r_clr_idx <= '0;
        end else if (w_clearing) begin
            r_clr_idx <= (r_clr_idx == c_LAST_IDX) ? '0 : r_clr_idx + 1'b1;
        end else if (clr_req_in) begin
            r_clr_idx <= '0;
        end
    end

    assign w_rd_in_range = ({1'b0, rd_addr_in} < c_NREGS);
    assign w_wr_ok       = w_ready && wr_en_in && w_rd_in_range
                           && !((ZERO_REG != 0) && (rd_addr_in == '0));
    assign w_set_ok      = ({1'b0, set_busy_addr_in} < c_NREGS)
                           && !((ZERO_REG != 0) && (set_busy_addr_in == '0));

    // Storage has no reset so it can map onto RAM; the clear engine zeroes it.
    always_ff @(posedge ms_risc32_mp_clk_in) begin
        if (!ms_risc32_mp_rst_in) begin
            if (w_clearing) begin
                r_regs[r_clr_idx] <= '0;
            end else if (w_wr_ok) begin
                r_regs[rd_addr_in] <= rd_in;
            end
        end
    end

    // Set is applied after clear so a same-edge reissue keeps the register busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (wr_en_in && w_rd_in_range) w_busy_nxt[rd_addr_in] = 1'b0;
        if (set_busy_en_in && w_set_ok) w_busy_nxt[set_busy_addr_in] = 1'b1;
    end

    always_ff @(posedge ms_risc32_mp_clk_in) begin
        if (ms_risc32_mp_rst_in || w_clearing || clr_req_in) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign w_rs_addr[0] = rs_1_addr_in;
    assign w_rs_addr[1] = rs_2_addr_in;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rs_data[p] = '0;
            w_rs_busy[p] = 1'b0;
            if (w_ready && ({1'b0, w_rs_addr[p]} < c_NREGS)
                && !((ZERO_REG != 0) && (w_rs_addr[p] == '0))) begin
                if ((BYPASS != 0) && wr_en_in && (w_rs_addr[p] == rd_addr_in)) begin
                    w_rs_data[p] = rd_in;
                end else begin
                    w_rs_data[p] = r_regs[w_rs_addr[p]];
                    w_rs_busy[p] = r_busy[w_rs_addr[p]];
                end
            end
        end
    end

    assign rs_1_out      = w_rs_data[0];
    assign rs_2_out      = w_rs_data[1];
    assign rs_1_busy_out = w_rs_busy[0];
    assign rs_2_busy_out = w_rs_busy[1];

endmodule
`default_nettype wire
